// File: rtl/desplazador_secuencial_ctrl.sv
// desplazador_secuencial_ctrl: sequential left/right shift controller.
// Accepts one request at a time on inicio. It shifts the latched word one
// position per clock, writes resultado on completion and pulses listo.
// Optional build macro ROTACION_EN adds input rotar. With rotar = 1 the
// operation is a rotate, and the amount is taken modulo N.
module desplazador_secuencial_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic         dir,
`ifdef ROTACION_EN
  input  logic         rotar,
`endif
  input  logic [N-1:0] palabraA,
  input  logic [N-1:0] palabraB,
  output logic [N-1:0] resultado,
  output logic         ocupado,
  output logic         listo
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [N-1:0] N_W = N'(N);

  typedef enum logic [1:0] {
    REPOSO,
    DESPLAZA,
    FIN
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [N-1:0]   trabajo_q, trabajo_d;
  logic [CW-1:0]  k_q, k_d;
  logic           dir_q, dir_d;
  logic [N-1:0]   resultado_q, resultado_d;
  logic           rotando;
  logic [CW-1:0]  k_carga;
  logic [N-1:0]   desplazado;

`ifdef ROTACION_EN
  logic           rot_q, rot_d;
  assign rotando = rot_q;
`else
  assign rotando = 1'b0;
`endif

  // Shift amount loaded on acceptance: clamp to N, or modulo N when rotating.
  always_comb begin
    k_carga = (palabraB > N_W) ? CW'(N) : CW'(palabraB);
`ifdef ROTACION_EN
    if (rotar) begin
      k_carga = CW'(palabraB % N_W);
    end
`endif
  end

  // One-position shift of the working word; the fill bit is zero or the wrapped bit.
  always_comb begin
    if (dir_q) begin
      desplazado = {trabajo_q[N-2:0], (rotando ? trabajo_q[N-1] : 1'b0)};
    end else begin
      desplazado = {(rotando ? trabajo_q[0] : 1'b0), trabajo_q[N-1:1]};
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    estado_d    = estado_q;
    trabajo_d   = trabajo_q;
    k_d         = k_q;
    dir_d       = dir_q;
    resultado_d = resultado_q;
`ifdef ROTACION_EN
    rot_d       = rot_q;
`endif
    unique case (estado_q)
      REPOSO: begin
        if (inicio) begin
          trabajo_d = palabraA;
          dir_d     = dir;
          k_d       = k_carga;
`ifdef ROTACION_EN
          rot_d     = rotar;
`endif
          if (k_carga == '0) begin
            resultado_d = palabraA;
            estado_d    = FIN;
          end else begin
            estado_d = DESPLAZA;
          end
        end
      end
      DESPLAZA: begin
        trabajo_d = desplazado;
        k_d       = k_q - CW'(1);
        if (k_q == CW'(1)) begin
          resultado_d = desplazado;
          estado_d    = FIN;
        end
      end
      FIN: begin
        estado_d = REPOSO;
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  // State and register update; synchronous reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= REPOSO;
      trabajo_q   <= '0;
      k_q         <= '0;
      dir_q       <= 1'b0;
      resultado_q <= '0;
`ifdef ROTACION_EN
      rot_q       <= 1'b0;
`endif
    end else begin
      estado_q    <= estado_d;
      trabajo_q   <= trabajo_d;
      k_q         <= k_d;
      dir_q       <= dir_d;
      resultado_q <= resultado_d;
`ifdef ROTACION_EN
      rot_q       <= rot_d;
`endif
    end
  end

  assign resultado = resultado_q;
  assign ocupado   = (estado_q != REPOSO);
  assign listo     = (estado_q == FIN);

endmodule
